bus_responder: RTL
==================

# bus_responder

Memory-mapped target on the CPU external bus, answering the strobes the CPU bus controller drives. Decodes a fixed address window, performs word and byte-lane writes into an internal bank of 16-bit registers, and returns registered read data with an active-low drive enable. Intended as the generic on-chip peripheral/scratch-register endpoint, and as the reference responder for CPU bus verification.

## Interface
Parameters:
- BASE_ADDR, 16'hF000, byte base address of the window; low ADDR_BITS+1 bits must be zero
- ADDR_BITS, 4, log2 of register count (window = 2^(ADDR_BITS+1) bytes)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- ADDR_BUF  in  16  byte address from bus controller
- DOUT_BUF  in  16  write data from CPU; high-byte writes arrive on [15:8]
- RDN_BUF  in  1  active-low read strobe
- WRN0_BUF  in  1  active-low write strobe, lane 0 (bits [7:0])
- WRN1_BUF  in  1  active-low write strobe, lane 1 (bits [15:8])
- DIN_BUF  out  16  read data to CPU
- DIN_OEN  out  1  active-low enable for DIN_BUF onto the shared bus
- SEL  out  1  high while a decoded access is in progress
- ERR  out  1  one-cycle pulse on strobe conflict inside the window
- ERR_COUNT  out  8  saturating conflict count (see Configuration)

## Operation
- Hit: ADDR_BUF[15:ADDR_BITS+1] == BASE_ADDR[15:ADDR_BITS+1]; word index = ADDR_BUF[ADDR_BITS:1]; ADDR_BUF[0] ignored (lane selection carried by strobes).
- Strobes registered once per cycle (rd_q, wr0_q, wr1_q); FSM acts on registered values, previous-cycle copies used for edge detection.
- FSM states: IDLE, READ, WRITE, CONFLICT.
- IDLE -> READ: hit, rd_q low, both wr high.
- IDLE -> WRITE: hit, rd_q high, either wr low.
- IDLE -> CONFLICT: hit, rd_q low and either wr low; ERR pulses for that cycle only.
- READ/WRITE/CONFLICT -> IDLE: all registered strobes high, or address leaves window.
- READ: DIN_BUF <= reg[word] every cycle (tracks address changes), DIN_OEN = 0, SEL = 1.
- WRITE: commit exactly once, on the IDLE->WRITE transition; lane 0 takes DOUT_BUF[7:0] if wr0 low, lane 1 takes DOUT_BUF[15:8] if wr1 low, both for word write. Strobes held low further cycles cause no further writes. New strobe in WRITE (other lane falling later) is ignored until return to IDLE.
- CONFLICT: no register write, DIN_OEN = 1, SEL = 1.
- Misses: no state change, DIN_OEN = 1, SEL = 0.

## Timing
- Reset values: all registers 16'h0000, DIN_BUF 16'h0000, DIN_OEN 1, SEL 0, ERR 0, ERR_COUNT 0, FSM IDLE.
- Strobe to FSM: 1 cycle (input register); FSM state registered, so READ entry = 2 cycles after strobe falls at the pins.
- Read latency: DIN_BUF valid and DIN_OEN low 2 rising edges after RDN_BUF low with valid address; DIN_OEN high 2 edges after RDN_BUF returns high.
- Write: register content updated 2 edges after strobe low; read-after-write to same word returns new data.
- Reset mid-access: reset wins; FSM to IDLE, pending write discarded, next access needs strobes to pass through high first.
- Strobes low at reset release: not treated as new access until seen high then low.

## Configuration
- BUS_RESPONDER_ERRCNT_EN defined: ERR_COUNT increments on each ERR pulse, saturates at 8'hFF, cleared only by RESET.
- Undefined: counter logic omitted, ERR_COUNT tied to 8'h00; ERR pulse unaffected.

## Test plan
- Word write 16'hBEEF to 16'hF004 (WRN0/WRN1 low 3 cycles) then read 16'hF004 -> DIN_BUF 16'hBEEF, DIN_OEN low 2 edges after RDN low; exactly one write observed.
- Byte write 8'h12 on [15:8] to 16'hF005 (WRN1 only) over word 16'hBEEF -> readback 16'h12EF; byte write 8'h34 to 16'hF004 (WRN0 only) -> 16'h1234.
- Access to 16'hE004 and 16'hF020 (outside ADDR_BITS=4 window) -> no register change, SEL 0, DIN_OEN stays 1.
- RDN and WRN0 low together at 16'hF002 -> ERR one-cycle pulse, no write, DIN_OEN 1; with BUS_RESPONDER_ERRCNT_EN, 300 conflicts -> ERR_COUNT 8'hFF, without -> 8'h00.
- RESET asserted one cycle after WRN0 falls at 16'hF006 -> reg stays 16'h0000; strobes held low through reset release cause no write.

Source files
------------

// File: rtl/bus_responder_if.sv
// Bus-controller side of the CPU external bus as seen by a memory-mapped responder.
// The master modport is the bus controller; the slave modport is the responder.
interface bus_responder_if;
  logic [15:0] ADDR_BUF;
  logic [15:0] DOUT_BUF;
  logic        RDN_BUF;
  logic        WRN0_BUF;
  logic        WRN1_BUF;
  logic [15:0] DIN_BUF;
  logic        DIN_OEN;
  logic        SEL;
  logic        ERR;
  logic [7:0]  ERR_COUNT;

  modport master (
    output ADDR_BUF, DOUT_BUF, RDN_BUF, WRN0_BUF, WRN1_BUF,
    input  DIN_BUF, DIN_OEN, SEL, ERR, ERR_COUNT
  );

  modport slave (
    input  ADDR_BUF, DOUT_BUF, RDN_BUF, WRN0_BUF, WRN1_BUF,
    output DIN_BUF, DIN_OEN, SEL, ERR, ERR_COUNT
  );
endinterface

// File: rtl/bus_responder.sv
// Memory-mapped bank of 16-bit registers answering CPU bus strobes.
// Optional feature: define BUS_RESPONDER_ERRCNT_EN for the saturating conflict counter.
module bus_responder #(
  parameter logic [15:0] BASE_ADDR = 16'hF000,
  parameter int          ADDR_BITS = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  bus_responder_if.slave  bus
);

  localparam int NUM_REGS = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, READ, WRITE, CONFLICT} state_t;

  state_t                 state;
  logic [15:0]            regs [NUM_REGS];
  logic [15:0]            addr_q;
  logic [15:0]            dout_q;
  logic                   rd_q, wr0_q, wr1_q;
  logic                   rd_p, wr0_p, wr1_p;
  logic                   hit;
  logic                   all_high;
  logic                   was_high;
  logic                   any_wr;
  logic [ADDR_BITS-1:0]   word;
  logic                   unused_addr_lsb;

  assign hit             = (addr_q[15:ADDR_BITS+1] == BASE_ADDR[15:ADDR_BITS+1]);
  assign word            = addr_q[ADDR_BITS:1];
  assign all_high        = rd_q & wr0_q & wr1_q;
  assign was_high        = rd_p & wr0_p & wr1_p;
  assign any_wr          = ~wr0_q | ~wr1_q;
  assign unused_addr_lsb = addr_q[0];

  // Strobes reset to "low" so strobes held low across reset release never
  // look like a fresh falling edge; they must be seen high first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q <= 16'h0000;
      dout_q <= 16'h0000;
      rd_q   <= 1'b0;
      wr0_q  <= 1'b0;
      wr1_q  <= 1'b0;
      rd_p   <= 1'b0;
      wr0_p  <= 1'b0;
      wr1_p  <= 1'b0;
    end else begin
      addr_q <= bus.ADDR_BUF;
      dout_q <= bus.DOUT_BUF;
      rd_q   <= bus.RDN_BUF;
      wr0_q  <= bus.WRN0_BUF;
      wr1_q  <= bus.WRN1_BUF;
      rd_p   <= rd_q;
      wr0_p  <= wr0_q;
      wr1_p  <= wr1_q;
    end
  end

  // A new access starts only when all strobes were high last cycle and at
  // least one is low now; the write commits once, on entry to WRITE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      bus.DIN_BUF <= 16'h0000;
      bus.DIN_OEN <= 1'b1;
      bus.SEL     <= 1'b0;
      bus.ERR     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      bus.ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (hit && was_high && !all_high) begin
            bus.SEL <= 1'b1;
            if (!rd_q && !any_wr) begin
              state       <= READ;
              bus.DIN_BUF <= regs[word];
              bus.DIN_OEN <= 1'b0;
            end else if (rd_q) begin
              state <= WRITE;
              if (!wr0_q) regs[word][7:0]  <= dout_q[7:0];
              if (!wr1_q) regs[word][15:8] <= dout_q[15:8];
            end else begin
              state   <= CONFLICT;
              bus.ERR <= 1'b1;
            end
          end
        end
        default: begin
          if (all_high || !hit) begin
            state       <= IDLE;
            bus.SEL     <= 1'b0;
            bus.DIN_OEN <= 1'b1;
          end else if (state == READ) begin
            bus.DIN_BUF <= regs[word];
          end
        end
      endcase
    end
  end

`ifdef BUS_RESPONDER_ERRCNT_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.ERR_COUNT <= 8'h00;
    end else if (bus.ERR && (bus.ERR_COUNT != 8'hFF)) begin
      bus.ERR_COUNT <= bus.ERR_COUNT + 8'h01;
    end
  end
`else
  assign bus.ERR_COUNT = 8'h00;
`endif

endmodule
